uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8N1 UART transmitter among `NUM_REQ` byte sources. It selects a requester, captures its byte, pulses the transmitter's trigger and holds its data input stable for the whole frame. It then follows the transmitter's busy flag to frame completion before granting again. It sits between the byte producers (debug console, status reporter, etc.) and the UART transmitter instance.

---
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ byte sources.
// A byte is captured only in IDLE, so tx_din stays frozen from trigger until frame end.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 2100,
    parameter int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      tx_trigger,
    output logic [DATA_W-1:0]         tx_din,
    input  logic                      tx_busy,
    output logic                      active,
    output logic [ID_W-1:0]           cur_id,
    output logic                      timeout_err
);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_trigger;
    logic [DATA_W-1:0]   r_din;
    logic                r_active;
    logic [ID_W-1:0]     r_cur_id;
    logic                r_timeout;

    logic                w_any;
    logic [ID_W-1:0]     w_grant;
    logic [ID_W-1:0]     w_idx;
    logic [DATA_W-1:0]   w_gdata;

    // Scan offsets from farthest to nearest so the nearest set bit after cur_id wins.
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_idx = ID_W'((int'(r_cur_id) + i) % NUM_REQ);
            if (req[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) w_gdata = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_ack     <= '0;
            r_trigger <= 1'b0;
            r_din     <= '0;
            r_active  <= 1'b0;
            r_cur_id  <= ID_W'(NUM_REQ - 1);
            r_timeout <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_trigger <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A busy transmitter here means a frame left over from before reset.
                    if (!tx_busy && w_any) begin
                        r_din          <= w_gdata;
                        r_ack[w_grant] <= 1'b1;
                        r_trigger      <= 1'b1;
                        r_cur_id       <= w_grant;
                        r_cnt          <= '0;
                        r_active       <= 1'b1;
                        r_state        <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        r_timeout <= 1'b1;
                        r_active  <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_active <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign ack         = r_ack;
    assign tx_trigger  = r_trigger;
    assign tx_din      = r_din;
    assign active      = r_active;
    assign cur_id      = r_cur_id;
    assign timeout_err = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: simple transmitter model plus a grant scoreboard.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int TMO     = 20;
    localparam int FRAME   = 10;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_trigger;
    logic [7:0]  tx_din;
    logic        tx_busy;
    logic        active;
    logic [1:0]  cur_id;
    logic        timeout_err;

    logic        m_busy;
    logic        man_busy;
    logic        model_en;

    exp_t        exp_q[$];
    exp_t        m_e;
    logic [7:0]  held;
    int          trig_cnt;
    int          checks;
    int          errors;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .BUSY_TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
        .tx_trigger(tx_trigger), .tx_din(tx_din), .tx_busy(tx_busy),
        .active(active), .cur_id(cur_id), .timeout_err(timeout_err)
    );

    assign tx_busy = model_en ? m_busy : man_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises two cycles after trigger and lasts FRAME cycles.
    initial begin
        m_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (model_en && tx_trigger && !rst) begin
                repeat (2) @(negedge clk);
                m_busy = 1'b1;
                repeat (FRAME) @(negedge clk);
                m_busy = 1'b0;
            end
        end
    end

    // Scoreboard: every trigger pops one expected grant; tx_din must hold while active.
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_trigger) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_trigger: got id=%0d din=%h, required no grant", cur_id, tx_din);
                end else begin
                    m_e = exp_q.pop_front();
                    if (cur_id !== m_e.id || tx_din !== m_e.data || ack !== (4'b0001 << m_e.id) || tx_busy !== 1'b0) begin
                        errors++;
                        $display("FAIL grant: got id=%0d din=%h ack=%b busy=%b, required id=%0d din=%h busy=0",
                                 cur_id, tx_din, ack, tx_busy, m_e.id, m_e.data);
                    end
                end
                held = tx_din;
                trig_cnt++;
            end else if (active) begin
                checks++;
                if (tx_din !== held || ack !== 4'b0000) begin
                    errors++;
                    $display("FAIL din_hold: got din=%h ack=%b, required din=%h ack=0000", tx_din, ack, held);
                end
            end
        end
    end

    task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((active || tx_busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL %s_idle: got active=%b pending=%0d, required idle within 400 cycles", name, active, exp_q.size());
        end
    endtask

    task automatic wait_trigs(input int target, input string name);
        int n;
        n = 0;
        while (trig_cnt < target && n < 600) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (trig_cnt < target) begin
            errors++;
            $display("FAIL %s_trigs: got %0d triggers, required %0d", name, trig_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0010;
        req_data = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || tx_trigger !== 1'b0 || tx_din !== 8'h00 || active !== 1'b0 ||
            timeout_err !== 1'b0 || cur_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_values: got ack=%b trig=%b din=%h act=%b tmo=%b id=%0d, required 0000 0 00 0 0 3",
                     ack, tx_trigger, tx_din, active, timeout_err, cur_id);
        end
        req = 4'b0000;
        req_data = '0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ack=%b act=%b, required 0000 0", ack, active);
        end
    endtask

    task automatic test_single();
        push_exp(2'd2, 8'hA5);
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0100 || tx_trigger !== 1'b1) begin
            errors++;
            $display("FAIL single_latency: got ack=%b trig=%b, required 0100 1", ack, tx_trigger);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || tx_trigger !== 1'b0 || active !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse: got ack=%b trig=%b act=%b, required 0000 0 1", ack, tx_trigger, active);
        end
        wait_idle("single");
        checks++;
        if (cur_id !== 2'd2 || tx_din !== 8'hA5 || active !== 1'b0) begin
            errors++;
            $display("FAIL single_after: got id=%0d din=%h act=%b, required 2 a5 0", cur_id, tx_din, active);
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset();
        push_exp(2'd0, 8'h10);
        push_exp(2'd1, 8'h21);
        push_exp(2'd2, 8'h32);
        push_exp(2'd3, 8'h43);
        push_exp(2'd0, 8'h10);
        base = trig_cnt;
        req_data = 32'h4332_2110;
        req = 4'b1111;
        wait_trigs(base + 5, "all");
        req = 4'b0000;
        wait_idle("all");
    endtask

    task automatic test_rr_skip();
        int base;
        do_reset();
        base = trig_cnt;
        push_exp(2'd1, 8'h5B);
        req_data = 32'h0000_5B0A;
        req = 4'b0010;
        wait_trigs(base + 1, "skip_first");
        push_exp(2'd0, 8'h0A);
        push_exp(2'd1, 8'h5B);
        req = 4'b0011;
        wait_trigs(base + 3, "skip");
        req = 4'b0000;
        wait_idle("skip");
    endtask

    task automatic test_timeout();
        int n;
        model_en = 1'b0;
        man_busy = 1'b0;
        push_exp(2'd0, 8'h5A);
        req_data[7:0] = 8'h5A;
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        checks++;
        if (tx_trigger !== 1'b1) begin
            errors++;
            $display("FAIL timeout_trigger: got trig=%b, required 1", tx_trigger);
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != TMO || active !== 1'b0) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles act=%b, required %0d cycles act=0", n, active, TMO);
        end
        @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got tmo=%b, required 0", timeout_err);
        end
        model_en = 1'b1;
        push_exp(2'd3, 8'hC7);
        req_data[31:24] = 8'hC7;
        req = 4'b1000;
        wait_trigs(trig_cnt + 1, "after_timeout");
        req = 4'b0000;
        wait_idle("after_timeout");
    endtask

    task automatic test_reset_midframe();
        int n;
        model_en = 1'b0;
        man_busy = 1'b0;
        push_exp(2'd1, 8'h77);
        req_data[15:8] = 8'h77;
        req = 4'b0010;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (active !== 1'b1) begin
            errors++;
            $display("FAIL midframe_active: got act=%b, required 1", active);
        end
        req_data[31:24] = 8'h99;
        req = 4'b1000;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || tx_trigger !== 1'b0 || tx_din !== 8'h00 || active !== 1'b0 || cur_id !== 2'd3) begin
            errors++;
            $display("FAIL midframe_reset: got ack=%b trig=%b din=%h act=%b id=%0d, required 0000 0 00 0 3",
                     ack, tx_trigger, tx_din, active, cur_id);
        end
        rst = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack !== 4'b0000 || active !== 1'b0) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL midframe_hold: got %0d grant cycles while busy, required 0", n);
        end
        push_exp(2'd3, 8'h99);
        man_busy = 1'b0;
        n = 0;
        while (tx_trigger !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        req = 4'b0000;
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL midframe_regrant: got no trigger in %0d cycles, required a grant", n);
        end
        @(negedge clk);
        man_busy = 1'b1;
        repeat (3) @(negedge clk);
        man_busy = 1'b0;
        wait_idle("midframe");
        model_en = 1'b1;
    endtask

    task automatic test_hold_din();
        push_exp(2'd2, 8'h3C);
        req_data[23:16] = 8'h3C;
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        repeat (4) @(negedge clk);
        req_data[23:16] = 8'hC3;
        wait_idle("hold");
        checks++;
        if (tx_din !== 8'h3C) begin
            errors++;
            $display("FAIL hold_after_frame: got din=%h, required 3c", tx_din);
        end
        push_exp(2'd2, 8'hC3);
        req = 4'b0100;
        @(negedge clk);
        req = 4'b0000;
        wait_idle("hold2");
        checks++;
        if (tx_din !== 8'hC3) begin
            errors++;
            $display("FAIL hold_next_grant: got din=%h, required c3", tx_din);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        trig_cnt = 0;
        held = '0;
        model_en = 1'b1;
        man_busy = 1'b0;
        rst = 1'b1;
        req = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_rr_skip();
        test_timeout();
        test_reset_midframe();
        test_hold_din();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within 500000 time units");
        $fatal(1);
    end

endmodule
